// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin scheduler in front of an 8:1 data multiplexer. One pending
// requester is chosen, its slot of in_data is captured into an output
// register, and the captured word is offered downstream with valid/ready.
//
// Handshake semantics: a transfer happens on a rising clk edge where
// out_valid and out_ready are both high. While out_valid is high and
// out_ready is low, sel, grant, out_data and out_valid stay frozen.
// ack is a combinational one-hot pulse, high only in the cycle in which
// out_valid & out_ready is present, on the requester being accepted.
//
// Optional build macro: ARB_LOCK_EN (adds the lock port for multi-beat
// bursts; the default build has no lock port).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   per-requester pending flags
//   in_data    packed mux inputs, requester i at [i*W +: W]
//   lock[7:0]  per-requester burst lock (ARB_LOCK_EN builds only)
//   sel[2:0]   registered index of the current grant
//   grant[7:0] registered one-hot grant, zero when idle
//   ack[7:0]   one-hot accept pulse during the handshake cycle
//   out_data   registered selected data
//   out_valid  out_data valid
//   out_ready  downstream accept
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
   parameter int W = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [7:0]     req,
   input  logic [8*W-1:0] in_data,
`ifdef ARB_LOCK_EN
   input  logic [7:0]     lock,
`endif
   output logic [2:0]     sel,
   output logic [7:0]     grant,
   output logic [7:0]     ack,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     ptr_q, ptr_d;
   logic [2:0]     sel_q, sel_d;
   logic [7:0]     grant_q, grant_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic           out_valid_q, out_valid_d;

   logic [7:0]     lock_w;
   logic           lock_hit;
   logic           hs;
   logic [7:0]     arb_req;
   logic [2:0]     arb_start;
   logic           arb_found;
   logic [2:0]     arb_idx;
   logic [W-1:0]   slot [8];

`ifdef ARB_LOCK_EN
   assign lock_w = lock;
`else
   assign lock_w = 8'h00;
`endif

   // Unpack the mux inputs once so the data select is a plain array index.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         slot[i] = in_data[i*W +: W];
      end
   end

   assign hs = out_valid_q & out_ready;

   // Only the lock bit of the granted requester matters.
   assign lock_hit = lock_w[sel_q];

   // Arbitration inputs. In IDLE the search starts at ptr. At a handshake
   // the accepted requester is masked and the search starts just past it,
   // unless its lock is held, in which case it is searched first so a
   // still-requesting burst owner wins again.
   always_comb begin
      arb_req   = req;
      arb_start = ptr_q;
      if (state_q == ST_BUSY) begin
         if (lock_hit) begin
            arb_req   = req;
            arb_start = sel_q;
         end else begin
            arb_req   = req & ~(8'h01 << sel_q);
            arb_start = sel_q + 3'd1;
         end
      end
   end

   // Circular priority scan: the candidate closest to arb_start (in
   // increasing index order, mod 8) wins. Scanning offsets from far to
   // near lets the nearest hit overwrite the others.
   always_comb begin
      logic [2:0] cand;
      cand      = '0;
      arb_found = 1'b0;
      arb_idx   = '0;
      for (int i = 7; i >= 0; i--) begin
         cand = arb_start + 3'(i);
         if (arb_req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // State register (with all datapath registers).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         grant_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         grant_q     <= grant_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Back-to-back transfers stay in BUSY; only an empty
            // re-arbitration at the handshake returns to IDLE.
            if (hs && !arb_found) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic.
   always_comb begin
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      grant_d     = grant_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      ack         = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               sel_d       = arb_idx;
               grant_d     = 8'h01 << arb_idx;
               out_data_d  = slot[arb_idx];
               out_valid_d = 1'b1;
            end
         end
         ST_BUSY: begin
            if (hs) begin
               ack = grant_q;
               // A locked owner keeps the pointer so fairness resumes
               // from the same place once the burst ends.
               if (!lock_hit) begin
                  ptr_d = sel_q + 3'd1;
               end
               if (arb_found) begin
                  sel_d      = arb_idx;
                  grant_d    = 8'h01 << arb_idx;
                  out_data_d = slot[arb_idx];
               end else begin
                  // sel and out_data keep their last values; they are
                  // meaningless while out_valid is low.
                  grant_d     = 8'h00;
                  out_valid_d = 1'b0;
               end
            end
         end
         default: begin
            grant_d     = 8'h00;
            out_valid_d = 1'b0;
         end
      endcase
   end

   assign sel       = sel_q;
   assign grant     = grant_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mux_rr_arbiter: directed scenarios with literal expectations
// followed by randomized requester traffic checked every cycle against a
// transaction-level model of the round-robin rules.
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic [7:0]     req;
   logic [8*W-1:0] in_data;
   logic           out_ready;
   logic [2:0]     sel;
   logic [7:0]     grant;
   logic [7:0]     ack;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic [7:0]     lock_v;

`ifdef ARB_LOCK_EN
   logic [7:0]     lock;
   assign lock_v = lock;
`else
   assign lock_v = 8'h00;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   mux_rr_arbiter #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .sel       (sel),
      .grant     (grant),
      .ack       (ack),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Holds only what the rules talk about: whether a word is on offer,
   // whose it is, what it is, and where the next search begins.
   bit           m_busy;
   int           m_sel;
   int           m_ptr;
   logic [W-1:0] m_data;

   function automatic int pick(input logic [7:0] m, input int start);
      for (int k = 0; k < 8; k++) begin
         if (m[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] slot_of(input int idx);
      return in_data[idx*W +: W];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_sel  <= 0;
         m_ptr  <= 0;
         m_data <= '0;
      end else if (!m_busy) begin
         if (pick(req, m_ptr) >= 0) begin
            m_busy <= 1'b1;
            m_sel  <= pick(req, m_ptr);
            m_data <= slot_of(pick(req, m_ptr));
         end
      end else if (out_ready) begin
         if (lock_v[m_sel]) begin
            if (pick(req, m_sel) >= 0) begin
               m_sel  <= pick(req, m_sel);
               m_data <= slot_of(pick(req, m_sel));
            end else begin
               m_busy <= 1'b0;
            end
         end else begin
            m_ptr <= (m_sel + 1) % 8;
            if (pick(req & ~(8'h01 << m_sel), (m_sel + 1) % 8) >= 0) begin
               m_sel  <= pick(req & ~(8'h01 << m_sel), (m_sel + 1) % 8);
               m_data <= slot_of(pick(req & ~(8'h01 << m_sel), (m_sel + 1) % 8));
            end else begin
               m_busy <= 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (check_en) begin
         check("cyc_valid", {31'd0, out_valid}, {31'd0, m_busy});
         check("cyc_grant", {24'd0, grant}, m_busy ? (32'h1 << m_sel) : 32'h0);
         check("cyc_ack", {24'd0, ack}, (m_busy && out_ready) ? (32'h1 << m_sel) : 32'h0);
         if (m_busy) begin
            check("cyc_sel", {29'd0, sel}, m_sel);
            check("cyc_data", {28'd0, out_data}, {28'd0, m_data});
         end
      end
   end

   // Requester-side memory of what was accepted in the previous cycle.
   logic [7:0] ack_seen  = 8'h00;
   logic [7:0] lock_seen = 8'h00;
   always @(negedge clk) begin
      ack_seen  <= ack;
      lock_seen <= lock_v;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n     = 1'b0;
      req       = 8'h00;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      lock      = 8'h00;
`endif
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic rand_cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         if (ack_seen[i] && !(lock_seen[i] && ($urandom_range(0, 1) == 1))) begin
            req[i] = 1'b0;
         end else if (!req[i] && ($urandom_range(0, 3) == 0)) begin
            req[i] = 1'b1;
         end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
`ifdef ARB_LOCK_EN
      lock      = 8'($urandom) & 8'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) begin
         #1 rst_n = 1'b0;
         #1 rst_n = 1'b1;
         req = 8'h00;
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n     = 1'b0;
      req       = 8'hFF;
      in_data   = '0;
      out_ready = 1'b0;
`ifdef ARB_LOCK_EN
      lock      = 8'h00;
`endif
      #7 check_en = 1'b1;

      // Reset with every requester pending.
      repeat (2) @(negedge clk);
      check("reset_sel",   {29'd0, sel},       32'h0);
      check("reset_grant", {24'd0, grant},     32'h0);
      check("reset_ack",   {24'd0, ack},       32'h0);
      check("reset_data",  {28'd0, out_data},  32'h0);
      check("reset_valid", {31'd0, out_valid}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("first_sel",   {29'd0, sel},       32'h0);
      check("first_grant", {24'd0, grant},     32'h01);
      check("first_valid", {31'd0, out_valid}, 32'h1);

      // Single requester 2.
      do_reset();
      req       = 8'b0000_0100;
      in_data   = 32'h0000_0100;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("single_sel",  {29'd0, sel},      32'h2);
      check("single_data", {28'd0, out_data}, 32'h1);
      check("single_ack",  {24'd0, ack},      32'h04);
      @(posedge clk);
      #1 req = 8'h00;
      @(negedge clk);
      check("single_idle", {31'd0, out_valid}, 32'h0);
      check("single_ack_drop", {24'd0, ack},   32'h0);

      // Round robin over all eight, back-to-back.
      do_reset();
      req       = 8'hFF;
      out_ready = 1'b1;
      in_data   = 32'h7654_3210;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_sel",   {29'd0, sel},       k);
         check("rr_data",  {28'd0, out_data},  k);
         check("rr_ack",   {24'd0, ack},       32'h1 << k);
         check("rr_valid", {31'd0, out_valid}, 32'h1);
         @(posedge clk);
         #1 req[k] = 1'b0;
      end
      @(negedge clk);
      check("rr_idle_valid", {31'd0, out_valid}, 32'h0);
      check("rr_idle_grant", {24'd0, grant},     32'h0);

      // Backpressure on requester 5 (pointer is back at 0 after the wrap).
      req       = 8'h20;
      out_ready = 1'b0;
      in_data   = 32'h0010_0000;
      @(posedge clk);
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("bp_sel",   {29'd0, sel},      32'h5);
         check("bp_grant", {24'd0, grant},    32'h20);
         check("bp_data",  {28'd0, out_data}, 32'h1);
         check("bp_ack",   {24'd0, ack},      32'h0);
         in_data[20 +: 4] = ~in_data[20 +: 4];
      end
      out_ready = 1'b1;
      #1 check("bp_release_ack", {24'd0, ack}, 32'h20);
      @(posedge clk);
      #1 req = 8'h00;
      out_ready = 1'b0;
      @(negedge clk);
      check("bp_idle", {31'd0, out_valid}, 32'h0);

      // Pointer now 6: requester 7 wins, then reset mid-transfer.
      req = 8'h80;
      @(posedge clk);
      @(negedge clk);
      check("mid_sel", {29'd0, sel}, 32'h7);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_sel",   {29'd0, sel},       32'h0);
      check("mid_rst_grant", {24'd0, grant},     32'h0);
      check("mid_rst_ack",   {24'd0, ack},       32'h0);
      check("mid_rst_data",  {28'd0, out_data},  32'h0);
      check("mid_rst_valid", {31'd0, out_valid}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req = 8'h82;
      @(posedge clk);
      @(negedge clk);
      check("restart_sel", {29'd0, sel}, 32'h1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 req = 8'h80;
      @(negedge clk);
      check("b2b_sel", {29'd0, sel}, 32'h7);
      @(posedge clk);
      #1 req = 8'h00;
      out_ready = 1'b0;

`ifdef ARB_LOCK_EN
      // Locked burst from requester 3 while 4 waits.
      do_reset();
      req       = 8'h18;
      lock      = 8'h08;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("lock_g1_sel", {29'd0, sel}, 32'h3);
      check("lock_g1_ack", {24'd0, ack}, 32'h08);
      @(posedge clk);
      @(negedge clk);
      check("lock_g2_sel", {29'd0, sel}, 32'h3);
      check("lock_g2_ack", {24'd0, ack}, 32'h08);
      @(posedge clk);
      #1 lock = 8'h00;
      @(negedge clk);
      check("lock_g3_sel", {29'd0, sel}, 32'h3);
      check("lock_g3_ack", {24'd0, ack}, 32'h08);
      @(posedge clk);
      #1 req = 8'h10;
      @(negedge clk);
      check("lock_next_sel", {29'd0, sel}, 32'h4);
      @(posedge clk);
      #1 req = 8'h00;
      out_ready = 1'b0;
`endif

      // Randomized traffic against the model.
      do_reset();
      repeat (3000) rand_cycle();

      @(negedge clk);
      check_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin scheduler that shares the 8:1 multiplexer datapath among eight requesters. It picks one pending requester and drives the mux select. It captures the selected input into an output register and presents it downstream with a valid/ready handshake. It sits between the requester slots and the downstream consumer, replacing a hand-driven `sel`.

## Interface
- `W`, default 1: width of each requester's data slot.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous active-low reset; one clock, no other reset.
- `req`  input  8: per-requester request; bit i = requester i pending.
- `in_data`  input  8*W: packed mux inputs; requester i at `[i*W +: W]`.
- `lock`  input  8: per-requester grant lock; present only with `ARB_LOCK_EN`.
- `sel`  output  3: registered mux select, index of the current grant.
- `grant`  output  8: one-hot registered grant; all-zero when idle.
- `ack`  output  8: one-cycle one-hot pulse on the accepted requester in the handshake cycle.
- `out_data`  output  W: registered selected data.
- `out_valid`  output  1: `out_data` valid.
- `out_ready`  input  1: downstream accepts when high with `out_valid`.

## Operation
- State machine has two states: IDLE and BUSY. Internal 3-bit round-robin pointer `ptr`.
- IDLE: if `req` is nonzero, choose the first set bit scanning `ptr`, `ptr+1`, … mod 8. Register `sel`, `grant`, and `out_data = in_data[sel]`, set `out_valid=1`, and go to BUSY. If `req` is zero, stay in IDLE.
- BUSY: `sel`, `grant`, `out_data` and `out_valid` hold stable while `out_ready=0`. Changes on `in_data` or `req` are ignored.
- Handshake (`out_valid & out_ready`): pulse `ack[sel]` and set `ptr = sel+1` mod 8. In the same cycle, re-arbitrate over `req` with bit `sel` masked off:
  - If any bit remains set, load the new grant/data and stay in BUSY, giving back-to-back transfers with no bubble.
  - Otherwise clear `grant`, drop `out_valid`, and go to IDLE.
- Requester protocol: hold `req` high until `ack`, then deassert it the following cycle.
- A requester that drops `req` while granted does not abort its transfer; the captured data still completes.
- Pointer wrap: after a grant to requester 7, the search starts at requester 0.

## Timing
- Reset values: `sel=0`, `grant=0`, `ack=0`, `out_data=0`, `out_valid=0`, `ptr=0`, state IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-transfer clears all outputs immediately, and the pending transfer is lost without an `ack`.
- Latency: `req` sampled high in IDLE at edge N gives `out_valid=1` after edge N.
- `ack` is high only in the cycle where `out_valid & out_ready` is sampled, and deasserts the next cycle.
- Sustained throughput is one transfer per cycle when `out_ready` is held high and at least two requesters are pending.
- Fairness: with all 8 requesting continuously, grants run 0,1,…,7,0,…. No requester waits more than 7 transfers.

## Configuration
- `ARB_LOCK_EN` defined: the `lock` port exists.
  - If `lock[sel]=1` at the handshake, `ack[sel]` still pulses, `ptr` is not advanced and `sel` is not masked.
  - Requester `sel` is re-granted if its `req` is still high, which allows multi-beat bursts. The requester may keep `req` high after `ack` while `lock` is high.
  - `lock` bits for non-granted requesters are ignored.
- `ARB_LOCK_EN` undefined: no `lock` port; every handshake advances `ptr` and masks the acknowledged requester.

## Test plan
- Reset: drive `rst_n=0` with `req=8'hFF` -> all outputs 0. After release and one edge -> `sel=0`, `grant=8'h01`, `out_valid=1`.
- Single requester: `req=8'b0000_0100`, `in_data` slot 2 = 1, `out_ready=1` -> `sel=2`, `out_data=1`, `ack=8'h04` for one cycle. Requester then drops `req` -> IDLE, `out_valid=0`.
- Round-robin with wrap: `req=8'hFF` held, `out_ready=1`, requesters dropping `req` after `ack` -> grant order 0..7 back-to-back with `out_valid` continuously high, then IDLE.
- Backpressure: grant to requester 5, hold `out_ready=0` for 4 cycles while toggling `in_data` slot 5 -> `out_data`, `sel=5`, `grant` stable, no `ack`. Raising `out_ready` -> `ack=8'h20`.
- Reset mid-transfer: `out_valid=1` and `out_ready=0`, pulse `rst_n` low -> outputs clear without a clock edge. After release, arbitration restarts from `ptr=0`.
- `ARB_LOCK_EN` build: requester 3 holds `req` and `lock[3]`, and requester 4 also requests -> three consecutive grants to 3, each with an `ack`. Dropping `lock[3]` -> the next grant goes to 4.
